load_reg_arbiter: RTL and testbench

- Round-robin controller that shares one 4-bit load register between four requesters.
- Each requester presents a 4-bit value and a level request.
- The block picks one winner, drives the register's load strobe and data for exactly one cycle, then returns a one-cycle acknowledge to the winner.
- It sits between the game-logic requesters and the shared state register.
- It owns the register's load and data inputs. It does not own the register's clock or reset.

---
 rtl/load_reg_arbiter_pkg.sv | 21 ++
 rtl/load_reg_arbiter_rr_pick4.sv | 24 ++
 rtl/load_reg_arbiter.sv | 106 ++++++++++
 tb/tb_load_reg_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/load_reg_arbiter_pkg.sv
// Shared definitions for the load-register arbiter and related schedulers.
//   state_t       : FSM state encoding (IDLE/LOAD/ACK)
//   DEF_N_REQ/DW  : default requester count and data width
//   wrap_inc      : (i+1) mod 4 for two-bit round-robin pointers
package load_reg_arbiter_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_DW    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Two-bit arithmetic wraps naturally, giving (i+1) mod 4.
    function automatic logic [1:0] wrap_inc(input logic [1:0] i);
        return i + 2'd1;
    endfunction

endpackage

// File: rtl/load_reg_arbiter_rr_pick4.sv
// Combinational four-way round-robin picker.
//   e      : eligible requester bits
//   ptr    : highest-priority index; search runs ptr, ptr+1, ... mod 4
//   valid  : any bit of e set
//   winner : first set bit of e found by the search (ptr when !valid)
module rr_pick4 (
    input  logic [3:0] e,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] winner
);

    always_comb begin
        valid  = 1'b0;
        winner = ptr;
        for (int unsigned k = 0; k < 4; k++) begin
            if (!valid && e[ptr + 2'(k)]) begin
                valid  = 1'b1;
                winner = ptr + 2'(k);
            end
        end
    end

endmodule

// File: rtl/load_reg_arbiter.sv
// Round-robin controller sharing one load register between four requesters.
//   clk       : system clock, rising edge
//   rst       : synchronous active-low reset
//   req       : per-requester request level, held until ack
//   req_data  : packed requester values, lane i at [i*DW +: DW]
//   en_mask   : 1 = requester eligible for a grant
//   reg_load  : one-cycle load strobe to the shared register
//   reg_din   : data to the shared register
//   ack       : one-hot, one-cycle acknowledge to the winner
//   busy      : high while a transaction is in flight
//   grant_idx : current or most recent winner
module load_reg_arbiter
    import load_reg_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int DW    = DEF_DW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    input  logic [N_REQ-1:0]    en_mask,
    output logic                reg_load,
    output logic [DW-1:0]       reg_din,
    output logic [N_REQ-1:0]    ack,
    output logic                busy,
    output logic [1:0]          grant_idx
);

    state_t            state, state_n;
    logic [1:0]        ptr, ptr_n;
    logic              load_n;
    logic [DW-1:0]     din_n;
    logic [N_REQ-1:0]  ack_n;
    logic [1:0]        gidx_n;
    logic              busy_n;

    logic              pick_valid;
    logic [1:0]        pick;

    rr_pick4 u_pick (
        .e      (req & en_mask),
        .ptr    (ptr),
        .valid  (pick_valid),
        .winner (pick)
    );

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        load_n  = reg_load;
        din_n   = reg_din;
        ack_n   = ack;
        gidx_n  = grant_idx;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_n = ST_LOAD;
                    din_n   = req_data[pick*DW +: DW];
                    gidx_n  = pick;
                    load_n  = 1'b1;
                end
            end
            ST_LOAD: begin
                // grant_idx still holds the winner latched on entry to LOAD.
                load_n           = 1'b0;
                ack_n            = '0;
                ack_n[grant_idx] = 1'b1;
                state_n          = ST_ACK;
            end
            ST_ACK: begin
                ack_n   = '0;
                ptr_n   = wrap_inc(grant_idx);
                state_n = ST_IDLE;
            end
            default: begin
                load_n  = 1'b0;
                ack_n   = '0;
                state_n = ST_IDLE;
            end
        endcase
        // busy is registered, so it tracks the state being entered.
        busy_n = (state_n != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            ptr       <= 2'd0;
            reg_load  <= 1'b0;
            reg_din   <= '0;
            ack       <= '0;
            busy      <= 1'b0;
            grant_idx <= 2'd0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            reg_load  <= load_n;
            reg_din   <= din_n;
            ack       <= ack_n;
            busy      <= busy_n;
            grant_idx <= gidx_n;
        end
    end

endmodule

// File: tb/tb_load_reg_arbiter.sv
// Self-checking bench for load_reg_arbiter: a per-cycle vector table plus
// hand-written rotation and reset-abort sequences.
module tb_load_reg_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic [3:0]  en_mask;
    logic        reg_load;
    logic [3:0]  reg_din;
    logic [3:0]  ack;
    logic        busy;
    logic [1:0]  grant_idx;

    int checks = 0;
    int errors = 0;
    logic mon_on = 1'b0;

    load_reg_arbiter #(.N_REQ(4), .DW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .en_mask   (en_mask),
        .reg_load  (reg_load),
        .reg_din   (reg_din),
        .ack       (ack),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] data;
        logic [3:0]  en;
        logic        load;
        logic [3:0]  din;
        logic [3:0]  ack;
        logic        busy;
        logic [1:0]  gidx;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [15:0] d,
                                input logic [3:0] m, input logic l, input logic [3:0] di,
                                input logic [3:0] a, input logic b, input logic [1:0] g);
        vec_t v;
        v.rst = r; v.req = q; v.data = d; v.en = m;
        v.load = l; v.din = di; v.ack = a; v.busy = b; v.gidx = g;
        return v;
    endfunction

    task automatic step(input logic r, input logic [3:0] q, input logic [15:0] d, input logic [3:0] m);
        rst = r; req = q; req_data = d; en_mask = m;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic l, input logic [3:0] di,
                         input logic [3:0] a, input logic b, input logic [1:0] g);
        checks++;
        if (reg_load !== l || reg_din !== di || ack !== a || busy !== b || grant_idx !== g) begin
            errors++;
            $display("FAIL %s: got load=%b din=%h ack=%b busy=%b gidx=%0d, want load=%b din=%h ack=%b busy=%b gidx=%0d",
                     name, reg_load, reg_din, ack, busy, grant_idx, l, di, a, b, g);
        end
    endtask

    // Structural invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_on) begin
            checks++;
            if ((ack & (ack - 4'd1)) != 4'd0 || (reg_load && ack != 4'd0) ||
                (!busy && (reg_load || ack != 4'd0))) begin
                errors++;
                $display("FAIL invariant: got load=%b ack=%b busy=%b at %0t", reg_load, ack, busy, $time);
            end
        end
    end

    initial begin
        //             rst req      data      en       load din   ack      busy gidx
        vecs[0]  = mk(0, 4'b1111, 16'h4321, 4'hF,    0, 4'h0, 4'b0000, 0, 2'd0); // reset
        vecs[1]  = mk(0, 4'b1111, 16'h4321, 4'hF,    0, 4'h0, 4'b0000, 0, 2'd0);
        vecs[2]  = mk(1, 4'b0100, 16'h0A00, 4'hF,    1, 4'hA, 4'b0000, 1, 2'd2); // single req
        vecs[3]  = mk(1, 4'b0100, 16'h0A00, 4'hF,    0, 4'hA, 4'b0100, 1, 2'd2);
        vecs[4]  = mk(1, 4'b0000, 16'h0A00, 4'hF,    0, 4'hA, 4'b0000, 0, 2'd2); // ptr -> 3
        vecs[5]  = mk(1, 4'b0000, 16'h0A00, 4'hF,    0, 4'hA, 4'b0000, 0, 2'd2);
        vecs[6]  = mk(1, 4'b0011, 16'h0057, 4'b1110, 1, 4'h5, 4'b0000, 1, 2'd1); // mask
        vecs[7]  = mk(1, 4'b0011, 16'h00C7, 4'b1110, 0, 4'h5, 4'b0010, 1, 2'd1); // data change
        vecs[8]  = mk(1, 4'b0001, 16'h00C7, 4'b1110, 0, 4'h5, 4'b0000, 0, 2'd1); // ptr -> 2
        vecs[9]  = mk(1, 4'b0001, 16'h00C7, 4'b1110, 0, 4'h5, 4'b0000, 0, 2'd1);
        vecs[10] = mk(1, 4'b0001, 16'h00C7, 4'b1110, 0, 4'h5, 4'b0000, 0, 2'd1);
        vecs[11] = mk(1, 4'b1000, 16'h9000, 4'hF,    1, 4'h9, 4'b0000, 1, 2'd3); // persistent
        vecs[12] = mk(1, 4'b1000, 16'h9000, 4'h0,    0, 4'h9, 4'b1000, 1, 2'd3); // mask mid-op
        vecs[13] = mk(1, 4'b1000, 16'h9000, 4'hF,    0, 4'h9, 4'b0000, 0, 2'd3); // ptr -> 0
        vecs[14] = mk(1, 4'b1000, 16'h9000, 4'hF,    1, 4'h9, 4'b0000, 1, 2'd3);
        vecs[15] = mk(1, 4'b1000, 16'h9000, 4'hF,    0, 4'h9, 4'b1000, 1, 2'd3);
        vecs[16] = mk(1, 4'b0000, 16'h9000, 4'hF,    0, 4'h9, 4'b0000, 0, 2'd3); // ptr -> 0

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].data, vecs[i].en);
            check($sformatf("vec%0d", i), vecs[i].load, vecs[i].din, vecs[i].ack,
                  vecs[i].busy, vecs[i].gidx);
            mon_on = 1'b1;
        end

        // Rotation: all four held, lanes 1..4, ptr starts at 0.
        for (int g = 0; g < 5; g++) begin
            step(1, 4'b1111, 16'h4321, 4'hF);
            check($sformatf("rot%0d_load", g), 1, 4'(g % 4 + 1), 4'b0000, 1, 2'(g % 4));
            step(1, 4'b1111, 16'h4321, 4'hF);
            check($sformatf("rot%0d_ack", g), 0, 4'(g % 4 + 1), 4'(1 << (g % 4)), 1, 2'(g % 4));
            step(1, 4'b1111, 16'h4321, 4'hF);
            check($sformatf("rot%0d_idle", g), 0, 4'(g % 4 + 1), 4'b0000, 0, 2'(g % 4));
        end

        // ptr=1: requester 2 wins over 0, then reset aborts it in LOAD.
        step(1, 4'b0101, 16'h4321, 4'hF);
        check("abort_grant", 1, 4'h3, 4'b0000, 1, 2'd2);
        step(0, 4'b0101, 16'h4321, 4'hF);
        check("abort_reset", 0, 4'h0, 4'b0000, 0, 2'd0);
        step(1, 4'b0100, 16'h4321, 4'hF);
        check("regrant_load", 1, 4'h3, 4'b0000, 1, 2'd2);
        step(1, 4'b0100, 16'h4321, 4'hF);
        check("regrant_ack", 0, 4'h3, 4'b0100, 1, 2'd2);
        step(1, 4'b0000, 16'h4321, 4'hF);
        check("regrant_idle", 0, 4'h3, 4'b0000, 0, 2'd2);

        // ptr=3 now; reset in LOAD must return ptr to 0.
        step(1, 4'b1111, 16'h4321, 4'hF);
        check("ptr3_grant", 1, 4'h4, 4'b0000, 1, 2'd3);
        step(0, 4'b1111, 16'h4321, 4'hF);
        check("ptr_reset", 0, 4'h0, 4'b0000, 0, 2'd0);
        step(1, 4'b1111, 16'h4321, 4'hF);
        check("ptr0_grant", 1, 4'h1, 4'b0000, 1, 2'd0);
        step(1, 4'b1111, 16'h4321, 4'hF);
        check("ptr0_ack", 0, 4'h1, 4'b0001, 1, 2'd0);
        step(1, 4'b0000, 16'h4321, 4'hF);
        check("final_idle", 0, 4'h1, 4'b0000, 0, 2'd0);
        step(1, 4'b0000, 16'h4321, 4'hF);
        check("no_req_idle", 0, 4'h1, 4'b0000, 0, 2'd0);

        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
